// File: rtl/noc_inj_pkg.sv
// Shared types and 7-segment helpers for the NoC packet injector.
// Pure declarations; no state, no latency, no flow control.
package noc_inj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_SHOT
  } inj_state_t;

  // Segment patterns a..g (bit6..0), active-high, for digits 0-9
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    if (digit > 4'd9) return 7'b0000000;
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/noc_packet_injector_key_debounce.sv
// Key conditioner: 2-flop sync, stable-count debounce, registered rising-edge pulse.
// Pulse appears DEB_CYCLES+1 edges after the raw key is first sampled; no backpressure.
module key_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          deb_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      cnt_q     <= '0;
      key_pulse <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_raw};
      key_pulse <= 1'b0;
      // Any sample agreeing with the debounced level restarts the count
      if (sync_q[1] != deb_q) begin
        if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          deb_q     <= sync_q[1];
          cnt_q     <= '0;
          key_pulse <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Manual NoC stimulus: key-edited data/router, continuous or single-shot injection, 7-seg display.
// All outputs registered, 1 cycle behind state; single-shot holds the packet until the target acks.
module noc_packet_injector
  import noc_inj_pkg::*;
#(
  parameter int ROUTERS    = 5,
  parameter int DATA_W     = 6,
  parameter int DEB_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sw_on,
  input  logic                          sw_mode,
  input  logic                          sw_sel_data,
  input  logic                          sw_sel_router,
  input  logic                          key_inc,
  input  logic                          key_dec,
  input  logic                          key_send,
  input  logic [ROUTERS-1:0]            ack,
  output logic [ROUTERS*(DATA_W+1)-1:0] out_router,
  output logic                          busy,
  output logic [7:0]                    sent_cnt,
  output logic [6:0]                    hex_data0,
  output logic [6:0]                    hex_data1,
  output logic [6:0]                    hex_router0,
  output logic [6:0]                    hex_router1
);

  localparam int PKT_W = DATA_W + 1;
  localparam int RW    = $clog2(ROUTERS);

  logic              inc_pulse, dec_pulse, send_pulse;
  logic [DATA_W-1:0] data_q, shot_data_q;
  logic [RW-1:0]     router_q, shot_rt_q, rt_inc, rt_dec;
  inj_state_t        state_q, state_d;
  logic              shot_latch, shot_done, done_q;
  logic [ROUTERS*PKT_W-1:0] pkt_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk(clk), .rst(rst), .key_raw(key_inc), .key_pulse(inc_pulse));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clk(clk), .rst(rst), .key_raw(key_dec), .key_pulse(dec_pulse));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_send (
    .clk(clk), .rst(rst), .key_raw(key_send), .key_pulse(send_pulse));

  assign rt_inc = (router_q == RW'(ROUTERS - 1)) ? '0 : router_q + RW'(1);
  assign rt_dec = (router_q == '0) ? RW'(ROUTERS - 1) : router_q - RW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      router_q    <= '0;
      shot_data_q <= '0;
      shot_rt_q   <= '0;
      state_q     <= ST_IDLE;
    end else begin
      // Simultaneous inc and dec cancel out
      if (sw_sel_data && (inc_pulse != dec_pulse))
        data_q <= inc_pulse ? data_q + DATA_W'(1) : data_q - DATA_W'(1);
      if (sw_sel_router && (inc_pulse != dec_pulse))
        router_q <= inc_pulse ? rt_inc : rt_dec;
      if (shot_latch) begin
        shot_data_q <= data_q;
        shot_rt_q   <= router_q;
      end
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shot_latch = 1'b0;
    shot_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sw_on && !sw_mode) begin
          state_d = ST_STREAM;
        end else if (sw_on && send_pulse) begin
          state_d    = ST_SHOT;
          shot_latch = 1'b1;
        end
      end
      ST_STREAM: begin
        if (!sw_on || sw_mode) state_d = ST_IDLE;
      end
      ST_SHOT: begin
        // Abort wins over a coincident ack: nothing is counted
        if (!sw_on) begin
          state_d = ST_IDLE;
        end else if (ack[shot_rt_q]) begin
          state_d   = ST_IDLE;
          shot_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_d = '0;
    for (int i = 0; i < ROUTERS; i++) begin
      if (state_q == ST_STREAM && int'(router_q) == i)
        pkt_d[i*PKT_W +: PKT_W] = {1'b1, data_q};
      else if (state_q == ST_SHOT && int'(shot_rt_q) == i)
        pkt_d[i*PKT_W +: PKT_W] = {1'b1, shot_data_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_router  <= '0;
      busy        <= 1'b0;
      done_q      <= 1'b0;
      sent_cnt    <= '0;
      hex_data0   <= 7'b0000001;
      hex_data1   <= 7'b0000001;
      hex_router0 <= 7'b0000001;
      hex_router1 <= 7'b0000001;
    end else begin
      out_router  <= pkt_d;
      busy        <= (state_q == ST_SHOT);
      done_q      <= shot_done;
      sent_cnt    <= sent_cnt + 8'(done_q);
      hex_data0   <= ~seg7(4'(int'(data_q) % 10));
      hex_data1   <= ~seg7(4'((int'(data_q) / 10) % 10));
      hex_router0 <= ~seg7(4'(int'(router_q) % 10));
      hex_router1 <= ~seg7(4'((int'(router_q) / 10) % 10));
    end
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector (ROUTERS=5, DATA_W=6, DEB_CYCLES=4).
module tb_noc_packet_injector;

  localparam int ROUTERS = 5;
  localparam int DATA_W  = 6;
  localparam int DEB     = 4;
  localparam int PKT_W   = DATA_W + 1;
  localparam int OW      = ROUTERS * PKT_W;

  // Active-low digit patterns, inverted by hand
  localparam logic [6:0] H0 = 7'b0000001;
  localparam logic [6:0] H1 = 7'b1001111;
  localparam logic [6:0] H2 = 7'b0010010;
  localparam logic [6:0] H3 = 7'b0000110;
  localparam logic [6:0] H4 = 7'b1001100;
  localparam logic [6:0] H5 = 7'b0100100;
  localparam logic [6:0] H6 = 7'b0100000;

  logic clk = 1'b0;
  logic rst, sw_on, sw_mode, sw_sel_data, sw_sel_router;
  logic key_inc, key_dec, key_send;
  logic [ROUTERS-1:0] ack;
  logic [OW-1:0] out_router;
  logic busy;
  logic [7:0] sent_cnt;
  logic [6:0] hex_data0, hex_data1, hex_router0, hex_router1;

  int total = 0;
  int bad   = 0;

  noc_packet_injector #(.ROUTERS(ROUTERS), .DATA_W(DATA_W), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sw_on(sw_on), .sw_mode(sw_mode),
    .sw_sel_data(sw_sel_data), .sw_sel_router(sw_sel_router),
    .key_inc(key_inc), .key_dec(key_dec), .key_send(key_send), .ack(ack),
    .out_router(out_router), .busy(busy), .sent_cnt(sent_cnt),
    .hex_data0(hex_data0), .hex_data1(hex_data1),
    .hex_router0(hex_router0), .hex_router1(hex_router1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic inc, input logic dec, input logic snd);
    key_inc  = inc;
    key_dec  = dec;
    key_send = snd;
    tick(10);
    key_inc  = 1'b0;
    key_dec  = 1'b0;
    key_send = 1'b0;
    tick(10);
  endtask

  function automatic logic [OW-1:0] slice(input int r, input logic [PKT_W-1:0] v);
    logic [OW-1:0] s;
    s = '0;
    s[r*PKT_W +: PKT_W] = v;
    return s;
  endfunction

  initial begin
    rst = 1'b1; sw_on = 1'b0; sw_mode = 1'b0; sw_sel_data = 1'b0; sw_sel_router = 1'b0;
    key_inc = 1'b0; key_dec = 1'b0; key_send = 1'b0; ack = '0;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", out_router, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", sent_cnt, 8'd0);
    chk("rst_hd0", hex_data0, H0);
    chk("rst_hd1", hex_data1, H0);
    chk("rst_hr0", hex_router0, H0);
    chk("rst_hr1", hex_router1, H0);

    // Router wrap
    tick(1);
    sw_sel_router = 1'b1;
    press(1'b0, 1'b1, 1'b0);
    chk("rt_dec_wrap", hex_router0, H4);
    chk("rt_dec_tens", hex_router1, H0);
    press(1'b1, 1'b0, 1'b0);
    chk("rt_inc_wrap", hex_router0, H0);
    press(1'b1, 1'b0, 1'b0);
    chk("rt_inc1", hex_router0, H1);
    press(1'b1, 1'b1, 1'b0);
    chk("rt_cancel", hex_router0, H1);

    // Data wrap
    sw_sel_router = 1'b0;
    sw_sel_data   = 1'b1;
    press(1'b0, 1'b1, 1'b0);
    chk("dat_dec_wrap1", hex_data1, H6);
    chk("dat_dec_wrap0", hex_data0, H3);
    press(1'b1, 1'b0, 1'b0);
    chk("dat_inc_wrap1", hex_data1, H0);
    chk("dat_inc_wrap0", hex_data0, H0);
    press(1'b0, 1'b1, 1'b0);
    chk("dat_dec63_1", hex_data1, H6);
    chk("dat_dec63_0", hex_data0, H3);

    // Continuous: router 2, data 5
    sw_sel_data   = 1'b0;
    sw_sel_router = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    chk("rt_two", hex_router0, H2);
    sw_sel_router = 1'b0;
    sw_sel_data   = 1'b1;
    for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 1'b0);
    chk("dat_five", hex_data0, H5);
    sw_on = 1'b1;
    tick(3);
    @(negedge clk);
    chk("stream_on", out_router, slice(2, 7'b1000101));
    tick(1);
    key_inc = 1'b1;
    tick(7);
    @(negedge clk);
    chk("stream_key_lat_pre", out_router, slice(2, 7'b1000101));
    tick(1);
    @(negedge clk);
    chk("stream_key_lat", out_router, slice(2, 7'b1000110));
    tick(1);
    key_inc = 1'b0;
    tick(10);
    sw_on = 1'b0;
    tick(1);
    @(negedge clk);
    chk("stream_off_pre", out_router, slice(2, 7'b1000110));
    tick(1);
    @(negedge clk);
    chk("stream_off", out_router, '0);
    tick(1);

    // Single-shot: router 1, data 9
    sw_sel_data   = 1'b0;
    sw_sel_router = 1'b1;
    press(1'b0, 1'b1, 1'b0);
    sw_sel_router = 1'b0;
    sw_sel_data   = 1'b1;
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
    sw_mode = 1'b1;
    sw_on   = 1'b1;
    tick(3);
    @(negedge clk);
    chk("shot_idle", out_router, '0);
    tick(1);
    press(1'b0, 1'b0, 1'b1);
    chk("shot_pkt", out_router, slice(1, 7'b1001001));
    chk("shot_busy", busy, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    chk("shot_hold", out_router, slice(1, 7'b1001001));
    chk("shot_hd1", hex_data1, H1);
    chk("shot_hd0", hex_data0, H0);
    ack = 5'b01000;
    tick(3);
    @(negedge clk);
    chk("shot_wrong_ack", out_router, slice(1, 7'b1001001));
    chk("shot_wrong_busy", busy, 1'b1);
    chk("shot_wrong_cnt", sent_cnt, 8'd0);
    tick(1);
    ack = 5'b00010;
    tick(1);
    @(negedge clk);
    chk("shot_ack_busy_pre", busy, 1'b1);
    chk("shot_ack_cnt_pre", sent_cnt, 8'd0);
    tick(1);
    ack = '0;
    @(negedge clk);
    chk("shot_done_out", out_router, '0);
    chk("shot_done_busy", busy, 1'b0);
    chk("shot_done_cnt", sent_cnt, 8'd1);
    tick(1);

    // Bounce: 2-cycle toggling never survives 4 stable samples
    for (int i = 0; i < 10; i++) begin
      key_inc = ~key_inc;
      tick(2);
    end
    key_inc = 1'b0;
    tick(10);
    @(negedge clk);
    chk("bounce_hd1", hex_data1, H1);
    chk("bounce_hd0", hex_data0, H0);
    tick(1);

    // Reset during SHOT
    press(1'b0, 1'b0, 1'b1);
    chk("shot2_pkt", out_router, slice(1, 7'b1001010));
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    chk("rst_shot_out", out_router, '0);
    chk("rst_shot_cnt", sent_cnt, 8'd0);
    chk("rst_shot_busy", busy, 1'b0);
    chk("rst_shot_hd0", hex_data0, H0);
    tick(1);
    rst = 1'b0;
    tick(3);
    @(negedge clk);
    chk("post_rst_out", out_router, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_packet_injector.md
# noc_packet_injector

Parametrised manual stimulus source for NoC bring-up on the FPGA board: switches and keys select a payload and a destination router, and the block injects a packet into that router's input slice. It supports two modes. Continuous mode drives the packet for as long as injection is enabled. Single-shot mode drives one latched packet until the target router acknowledges it. The block debounces the board keys, wraps the selection counters in range, counts delivered packets, and shows data and router on two-digit decimal 7-segment displays.

## Interface
- `ROUTERS`, 5: number of routers; legal range 2..99.
- `DATA_W`, 6: payload width; packet width `PKT_W` = `DATA_W`+1, with MSB = valid.
- `DEB_CYCLES`, 4: consecutive stable samples required for a debounced key change; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sw_on` in 1: injection enable.
- `sw_mode` in 1: 0 = continuous, 1 = single-shot.
- `sw_sel_data` in 1: keys edit the payload.
- `sw_sel_router` in 1: keys edit the destination router.
- `key_inc`, `key_dec`, `key_send` in 1 each: raw asynchronous board keys, active-high.
- `ack` in `ROUTERS`: per-router accept, active-high, sampled only in SHOT.
- `out_router` out `ROUTERS*PKT_W`: slice i = bits [i*PKT_W +: PKT_W].
- `busy` out 1: high in SHOT.
- `sent_cnt` out 8: completed single-shot packets, wraps 255→0.
- `hex_data0`, `hex_data1`, `hex_router0`, `hex_router1` out 7 each: ones/tens digits, active-low, bit6..0 = segments a..g.

## Operation
- Each key passes through a 2-flop synchronizer and then a debouncer. The debounced level changes only after the synchronized value has differed from it for `DEB_CYCLES` consecutive cycles. A one-cycle pulse is emitted on each debounced rising edge.
- `data` register (`DATA_W` bits):
  - inc pulse with `sw_sel_data`=1 → +1; wraps 2^DATA_W−1→0.
  - dec pulse → −1; wraps 0→2^DATA_W−1.
- `router` register:
  - Same rules, gated by `sw_sel_router`.
  - Wraps ROUTERS−1↔0; never leaves the range 0..ROUTERS−1.
- Inc and dec pulses in the same cycle cancel (no change). With both select switches high, both registers update.
- FSM states IDLE, STREAM, SHOT:
  - IDLE: all slices 0. `sw_on`=1 with `sw_mode`=0 → STREAM. `sw_on`=1 with `sw_mode`=1 and a send pulse → SHOT, latching `data` and `router` into `shot_data` and `shot_rt`.
  - STREAM: slice `router` = {1,`data`} and all other slices 0, tracking live register edits. Exit to IDLE when `sw_on`=0 or `sw_mode`=1.
  - SHOT: slice `shot_rt` = {1,`shot_data`}; key edits do not affect it. `ack[shot_rt]`=1 → IDLE and `sent_cnt`+1. `ack` on other routers is ignored. `sw_on`=0 aborts to IDLE without counting.
  - Send pulses outside IDLE in single-shot mode are dropped.
- Displays:
  - ones digit = value mod 10, tens digit = value/10 mod 10.
  - `hex_data` shows `data` mod 100.
  - Digit patterns (before inversion) 0–9 = 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.

## Timing
- Reset values: `data`=0, `router`=0, FSM=IDLE, `out_router`=0, `busy`=0, `sent_cnt`=0, all key pipelines cleared (debounced=0), all hex = 7'b0000001 ("00").
- Key latency: raw key first sampled high at edge k and held → `data`/`router` updated at edge k+DEB_CYCLES+2.
- All outputs are registered. `out_router`, `busy` and the hex outputs reflect register and state values with 1-cycle latency (the edge after the change).
- STREAM enter/exit: `out_router` becomes valid/zero at the edge after the deciding `sw_on`/`sw_mode` sample.
- SHOT completion: `ack[shot_rt]` sampled high at edge m → slice zero, `busy`=0 and `sent_cnt` incremented after edge m+1.
- `rst` mid-operation overrides everything at the next edge, including SHOT and in-flight debounces.

## Structure
- Package `noc_inj_pkg`:
  - FSM state enum.
  - 7-segment digit constant table.
  - digit→segment function.
- Sub-module `key_debounce` (synchronizer + stable counter + edge pulse), parametrised by `DEB_CYCLES`, instantiated three times.
- Top-level block holds the counters, FSM, output slice mux and display logic.

## Test plan
- Reset: assert `rst` 2 cycles → all slices 0, `busy`=0, `sent_cnt`=0, all hex = 7'b0000001.
- Router wrap (`ROUTERS`=5):
  - one dec press from 0 → router=4, `hex_router0`=~7'b0110011.
  - one inc press → 0.
  - inc+dec asserted together → unchanged.
- Data wrap: data=63, inc press → 0. Then dec → 63, with `hex_data1`=~7'b1011111 and `hex_data0`=~7'b1111001.
- Continuous: router=2, data=5, `sw_on`=1, `sw_mode`=0 → slice 2 = 7'b1000101 and others 0. Inc press → slice 2 = 7'b1000110. `sw_on`=0 → all 0 the next cycle.
- Single-shot: router=1, data=9, send press → slice 1 = 7'b1001001, `busy`=1.
  - Hold `ack`=0 for 10 cycles and edit data → slice unchanged.
  - `ack[3]`=1 → ignored.
  - `ack[1]`=1 → slice 0, `sent_cnt`=1.
- Bounce and abort:
  - key toggling every 2 cycles with `DEB_CYCLES`=4 → no change.
  - `rst` during SHOT → `out_router`=0 and `sent_cnt`=0 after the next edge.
